// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port RAM: clear-FSM state encoding,
// byte width, and the byte-enable merge used by both the write and bypass paths.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int BYTE_W     = 8;
  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / BYTE_W;

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BYTES-1:0]  be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: sweeps zeros through the array after reset or on request and
// muxes the array write port between the sweep and user writes.
//
//   state | meaning
//   CLEAR | zeroing mem[clr_addr], busy = 1, user writes/clr ignored
//   READY | normal operation, user writes accepted, clr starts a sweep
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] w_be,
  input  logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         clr,
  output logic                         busy,
  output logic                         wr_acc,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data,
  output logic [DATA_WIDTH/BYTE_W-1:0] mem_be
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_acc     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = w_addr;
    mem_data   = w_data;
    mem_be     = w_be;
    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q;
        mem_data   = '0;
        mem_be     = '1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) state_d = READY;
      end
      READY: begin
        wr_acc = we;
        mem_we = we & (|w_be);
        if (clr) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Nothing lands in the array on a reset edge, whatever state we were in.
    if (!rst_n) begin
      wr_acc = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Reported busy as soon as reset is asserted, before the first reset edge.
  assign busy = (state_q == CLEAR) | ~rst_n;

endmodule

// File: rtl/ram_nports.sv
// Parametrised 1W/NR RAM with byte enables, combinational or registered reads,
// optional write-first bypass, and a hardware clear engine.
module ram_nports
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_READ   = 2,
  parameter int REG_READ   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [DATA_WIDTH/8-1:0]        w_be,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
  input  logic                           clr,
  output logic                           busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wr_word;

  ram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .w_be     (w_be),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .clr      (clr),
    .busy     (busy),
    .wr_acc   (wr_acc),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_be   (mem_be)
  );

  assign mem_wr_word = DATA_WIDTH'(be_merge(MAX_DATA_W'(mem_q[mem_addr]),
                                            MAX_DATA_W'(mem_data),
                                            MAX_BYTES'(mem_be)));

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wr_word;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  hit;
    logic [DATA_WIDTH-1:0] rd_d;

    assign raddr  = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_rd = mem_q[raddr];
    assign hit    = (BYPASS != 0) && wr_acc && (raddr == w_addr);
    // Bypass word is the byte-merged result the write is about to store.
    assign fwd_word = DATA_WIDTH'(be_merge(MAX_DATA_W'(mem_rd),
                                           MAX_DATA_W'(w_data),
                                           MAX_BYTES'(w_be)));
    assign rd_d = busy ? '0 : (hit ? fwd_word : mem_rd);

    if (REG_READ != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
      end
      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end else begin : g_comb
      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_d;
    end
  end

endmodule

// File: doc/ram_nports.md
# ram_nports

Parametrised multi-port RAM with one write port and `NUM_READ` read ports. It is the successor to the team's fixed 1W/2R register-file RAM and adds:
- per-byte write enables;
- selectable combinational or registered reads;
- optional write-to-read bypass;
- a hardware clear engine that zeroes the whole array after reset or on request.

It serves as the register file / small scratchpad in datapath blocks.

## Interface
Parameters:
- `ADDR_WIDTH`, 3: address bits; depth `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 8: word width; must be a multiple of 8.
- `NUM_READ`, 2: number of read ports, 1..8.
- `REG_READ`, 1: 1 = registered reads (latency 1), 0 = combinational reads.
- `BYPASS`, 1: 1 = same-cycle write data forwarded to matching read ports (write-first); 0 = read-first.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `we`  in  1  write request.
- `w_be`  in  `DATA_WIDTH/8`  byte enables; bit i covers `w_data[8i+7:8i]`.
- `w_addr`  in  `ADDR_WIDTH`  write address.
- `w_data`  in  `DATA_WIDTH`  write data.
- `r_addr`  in  `NUM_READ*ADDR_WIDTH`  packed read addresses; port k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `r_data`  out  `NUM_READ*DATA_WIDTH`  packed read data; port k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `clr`  in  1  request a full-array clear.
- `busy`  out  1  clear engine active; writes ignored, reads return 0.

## Operation
- **Clear FSM states:**
  - CLEAR: writes 0 to `clr_addr`; `clr_addr` increments each cycle; at `clr_addr == DEPTH-1` it moves to READY.
  - READY: normal operation; `clr` = 1 moves to CLEAR with `clr_addr` = 0.
- **Reset:** `rst_n` = 0 at a rising edge forces state CLEAR, `clr_addr` = 0, `r_data` registers = 0. This applies mid-clear and mid-operation alike.
- **Write:**
  - Accepted only in READY with `we` = 1.
  - For each byte i with `w_be[i]` = 1, `mem[w_addr]` byte i <= `w_data` byte i; other bytes are unchanged.
  - `we` with `w_be` = 0 is a no-op.
- **Read, REG_READ = 1:** `r_data[k]` registered from `mem[r_addr[k]]` each edge.
- **Read, REG_READ = 0:** `r_data[k]` is combinational from `mem[r_addr[k]]`.
- **Bypass:**
  - With `BYPASS` = 1 and an accepted write where `r_addr[k] == w_addr`, port k sees the byte-merged word: new bytes where `w_be` = 1, old bytes elsewhere.
  - REG_READ = 1: the merged word appears in the registered output.
  - REG_READ = 0: the merged word appears combinationally in the same cycle.
  - With `BYPASS` = 0, port k sees the pre-write contents.
- **Multiple ports:** any number of read ports may share an address; each returns identical data.
- **While busy = 1:**
  - All `r_data` = 0 (registered path loads 0).
  - `we` and `clr` are ignored; `clr` does not restart an ongoing clear.

## Timing
- **Reset values:** `busy` = 1; `r_data` = 0.
- **Clear duration after reset:**
  - `busy` stays 1 while `rst_n` is low and for `DEPTH` rising edges after release; the clear writes occur on those edges.
  - `busy` drops after the `DEPTH`-th edge; the first write is accepted on the next edge.
- **Clear on request:** `clr` sampled in READY raises `busy` on the following cycle, which lasts `DEPTH` cycles.
- **Read latency:** REG_READ = 1 gives 1 cycle from address to data; REG_READ = 0 gives 0 cycles.
- **Write-to-read visibility without bypass:** a write at edge N is visible to any read sampled after edge N.
- **`clr` and `we` in the same READY cycle:** the write is performed, then the clear starts and overwrites it.

## Structure
- Shared package `ram_pkg`:
  - clear-FSM state enum `{CLEAR, READY}`;
  - `BYTE_W = 8` constant;
  - function for byte-enable merge.
- Natural sub-module `ram_clear_fsm`: owns state, `clr_addr` and `busy`, and drives the internal write mux (address, data, enable).
- The top module holds the array, byte-enable write logic and a generate loop over `NUM_READ` read ports.

## Test plan
Default parameters unless noted; DATA_WIDTH = 16 for byte-enable cases.
- **Reset/clear:** hold `rst_n` = 0 for 2 cycles, release. Expect `busy` = 1 for exactly 8 edges, then 0; all 8 addresses read 0. `we` during busy leaves `mem[3]` = 0.
- **Byte enable:** write `16'hABCD` `w_be` = 2'b11 to addr 5, then `16'h1200` `w_be` = 2'b10. Expect addr 5 reads `16'h12CD`; `w_be` = 2'b00 leaves it unchanged.
- **Multi-port:** NUM_READ = 4, all ports reading addr 2 = `8'h5A`, plus port 3 reading addr 7 = `8'h77`. Expect ports 0–2 = `8'h5A` and port 3 = `8'h77`, one cycle after the address.
- **Bypass:**
  - BYPASS = 1, REG_READ = 1: addr 4 holds `8'h11`; write `8'h22` to addr 4 while port 0 reads addr 4. Expect `8'h22` next cycle.
  - Same stimulus with BYPASS = 0: expect `8'h11`, then `8'h22` one cycle later.
- **Combinational read:** REG_READ = 0, BYPASS = 1: write `8'h3C` to addr 1 while port 1 reads addr 1. Expect `r_data` = `8'h3C` in the same cycle, before the edge.
- **Clear and reset mid-operation:** fill addrs 0–7 with `8'hFF`, pulse `clr`. Expect `busy` for 8 cycles and all reads 0. Assert `rst_n` = 0 at clear cycle 3: expect the clear to restart from addr 0 with a full 8 busy cycles after release.
